// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA pixel timing: pixel/line counters, syncs, active flag, coordinates, end-of-frame strobe.
// Define VGA_TIMING_SYNC_ACTIVE_HIGH_EN to make hSync/vSync active-high (idle 0) instead of active-low.
module vga_timing_gen #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic       clk25,
  input  logic       reset,
  output logic       hSync,
  output logic       vSync,
  output logic       active,
  output logic       screenEnd,
  output logic [9:0] x,
  output logic [8:0] y
);

  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(WIDTH);
  localparam logic [9:0] V_ACT    = 10'(HEIGHT);
  localparam logic [9:0] HS_START = 10'(WIDTH + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(HEIGHT + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(HEIGHT + V_FRONT + V_SYNC);
  localparam logic [8:0] Y_MAX    = 9'(HEIGHT - 1);

`ifdef VGA_TIMING_SYNC_ACTIVE_HIGH_EN
  localparam logic SYNC_ON = 1'b1;
`else
  localparam logic SYNC_ON = 1'b0;
`endif

  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       h_pulse;
  logic       v_pulse;
  logic       in_view;
  logic       frame_end;

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      h_count <= 10'd0;
      v_count <= 10'd0;
    end else if (h_count == H_LAST) begin
      h_count <= 10'd0;
      v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
    end else begin
      h_count <= h_count + 10'd1;
    end
  end

  assign h_pulse   = (h_count >= HS_START) && (h_count < HS_END);
  assign v_pulse   = (v_count >= VS_START) && (v_count < VS_END);
  assign in_view   = (h_count < H_ACT) && (v_count < V_ACT);
  assign frame_end = (h_count == 10'd0) && (v_count == V_ACT);

  // Reset gates the decodes directly so outputs reach idle values without waiting for a clock.
  always_comb begin
    hSync     = ~SYNC_ON;
    vSync     = ~SYNC_ON;
    active    = 1'b0;
    screenEnd = 1'b0;
    x         = 10'd0;
    y         = 9'd0;
    if (reset) begin
      hSync     = h_pulse ? SYNC_ON : ~SYNC_ON;
      vSync     = v_pulse ? SYNC_ON : ~SYNC_ON;
      active    = in_view;
      screenEnd = frame_end;
      x         = h_count;
      y         = (v_count < V_ACT) ? v_count[8:0] : Y_MAX;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line timing, plus a shrunken instance (24x19 totals) for frame-level behaviour.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_SYNC_ACTIVE_HIGH_EN
  localparam logic SYNC_IDLE = 1'b0;
`else
  localparam logic SYNC_IDLE = 1'b1;
`endif
  localparam logic SYNC_ON = ~SYNC_IDLE;

  logic       clk25;
  logic       reset;
  logic       d_hsync, d_vsync, d_active, d_screen_end;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic       s_hsync, s_vsync, s_active, s_screen_end;
  logic [9:0] s_x;
  logic [8:0] s_y;

  int check_count;
  int error_count;

  vga_timing_gen dut_full (
    .clk25(clk25), .reset(reset), .hSync(d_hsync), .vSync(d_vsync),
    .active(d_active), .screenEnd(d_screen_end), .x(d_x), .y(d_y)
  );

  // Small frame: H 16+2+3+3 = 24, V 12+2+2+3 = 19, frame = 456 cycles.
  vga_timing_gen #(
    .WIDTH(16), .HEIGHT(12), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_small (
    .clk25(clk25), .reset(reset), .hSync(s_hsync), .vSync(s_vsync),
    .active(s_active), .screenEnd(s_screen_end), .x(s_x), .y(s_y)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " d_x"}, 32'(d_x), 0);
    checkOutput({tag, " d_y"}, 32'(d_y), 0);
    checkOutput({tag, " d_active"}, 32'(d_active), 0);
    checkOutput({tag, " d_hsync"}, 32'(d_hsync), 32'(SYNC_IDLE));
    checkOutput({tag, " d_vsync"}, 32'(d_vsync), 32'(SYNC_IDLE));
    checkOutput({tag, " d_screen_end"}, 32'(d_screen_end), 0);
    checkOutput({tag, " s_x"}, 32'(s_x), 0);
    checkOutput({tag, " s_active"}, 32'(s_active), 0);
    checkOutput({tag, " s_vsync"}, 32'(s_vsync), 32'(SYNC_IDLE));
  endtask

  // Starts just after reset release (cycle 0) and samples 1 time unit after each rising edge.
  task automatic applyStimulus(input string run, input int n_cycles);
    int s_pulses, d_pulses, first_pulse, second_pulse, vs_low;
    s_pulses = 0; d_pulses = 0; first_pulse = -1; second_pulse = -1; vs_low = 0;
    for (int c = 0; c < n_cycles; c++) begin
      case (c)
        0: begin
          checkOutput({run, " c0 d_x"}, 32'(d_x), 0);
          checkOutput({run, " c0 d_y"}, 32'(d_y), 0);
          checkOutput({run, " c0 d_active"}, 32'(d_active), 1);
          checkOutput({run, " c0 d_hsync"}, 32'(d_hsync), 32'(SYNC_IDLE));
          checkOutput({run, " c0 s_active"}, 32'(s_active), 1);
        end
        1:   checkOutput({run, " c1 d_x"}, 32'(d_x), 1);
        15:  checkOutput({run, " c15 s_active"}, 32'(s_active), 1);
        16:  checkOutput({run, " c16 s_active"}, 32'(s_active), 0);
        17:  checkOutput({run, " c17 s_hsync"}, 32'(s_hsync), 32'(SYNC_IDLE));
        18:  checkOutput({run, " c18 s_hsync"}, 32'(s_hsync), 32'(SYNC_ON));
        20:  checkOutput({run, " c20 s_hsync"}, 32'(s_hsync), 32'(SYNC_ON));
        21:  checkOutput({run, " c21 s_hsync"}, 32'(s_hsync), 32'(SYNC_IDLE));
        24: begin
          checkOutput({run, " c24 s_x"}, 32'(s_x), 0);
          checkOutput({run, " c24 s_y"}, 32'(s_y), 1);
        end
        287: begin
          checkOutput({run, " c287 s_screen_end"}, 32'(s_screen_end), 0);
          checkOutput({run, " c287 s_y"}, 32'(s_y), 11);
        end
        288: begin
          checkOutput({run, " c288 s_screen_end"}, 32'(s_screen_end), 1);
          checkOutput({run, " c288 s_x"}, 32'(s_x), 0);
          checkOutput({run, " c288 s_y"}, 32'(s_y), 11);
          checkOutput({run, " c288 s_active"}, 32'(s_active), 0);
        end
        289: checkOutput({run, " c289 s_screen_end"}, 32'(s_screen_end), 0);
        335: checkOutput({run, " c335 s_vsync"}, 32'(s_vsync), 32'(SYNC_IDLE));
        336: checkOutput({run, " c336 s_vsync"}, 32'(s_vsync), 32'(SYNC_ON));
        383: checkOutput({run, " c383 s_vsync"}, 32'(s_vsync), 32'(SYNC_ON));
        384: checkOutput({run, " c384 s_vsync"}, 32'(s_vsync), 32'(SYNC_IDLE));
        455: begin
          checkOutput({run, " c455 s_x"}, 32'(s_x), 23);
          checkOutput({run, " c455 s_y"}, 32'(s_y), 11);
        end
        456: begin
          checkOutput({run, " c456 s_x"}, 32'(s_x), 0);
          checkOutput({run, " c456 s_y"}, 32'(s_y), 0);
          checkOutput({run, " c456 s_active"}, 32'(s_active), 1);
        end
        639: checkOutput({run, " c639 d_active"}, 32'(d_active), 1);
        640: begin
          checkOutput({run, " c640 d_active"}, 32'(d_active), 0);
          checkOutput({run, " c640 d_x"}, 32'(d_x), 640);
        end
        655: checkOutput({run, " c655 d_hsync"}, 32'(d_hsync), 32'(SYNC_IDLE));
        656: checkOutput({run, " c656 d_hsync"}, 32'(d_hsync), 32'(SYNC_ON));
        751: checkOutput({run, " c751 d_hsync"}, 32'(d_hsync), 32'(SYNC_ON));
        752: checkOutput({run, " c752 d_hsync"}, 32'(d_hsync), 32'(SYNC_IDLE));
        799: begin
          checkOutput({run, " c799 d_x"}, 32'(d_x), 799);
          checkOutput({run, " c799 d_y"}, 32'(d_y), 0);
          checkOutput({run, " c799 d_vsync"}, 32'(d_vsync), 32'(SYNC_IDLE));
        end
        800: begin
          checkOutput({run, " c800 d_x"}, 32'(d_x), 0);
          checkOutput({run, " c800 d_y"}, 32'(d_y), 1);
          checkOutput({run, " c800 d_active"}, 32'(d_active), 1);
        end
        default: ;
      endcase
      if (s_screen_end) begin
        s_pulses++;
        if (first_pulse < 0) first_pulse = c;
        else if (second_pulse < 0) second_pulse = c;
      end
      if (d_screen_end) d_pulses++;
      if (s_vsync == SYNC_ON) vs_low++;
      @(posedge clk25);
      #1;
    end
    checkOutput({run, " s_screen_end pulses"}, 32'(s_pulses), 2);
    checkOutput({run, " s_screen_end spacing"}, 32'(second_pulse - first_pulse), 456);
    checkOutput({run, " d_screen_end pulses"}, 32'(d_pulses), 0);
    checkOutput({run, " s_vsync pulse cycles"}, 32'(vs_low), 96);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    reset = 1'b0;
    repeat (5) @(posedge clk25);
    #1;
    checkResetState("reset");

    @(negedge clk25);
    reset = 1'b1;
    #1;
    applyStimulus("run1", 922);

    // Land mid-frame and mid-cycle so no clock edge can explain the change.
    repeat (150) @(posedge clk25);
    #7;
    checkOutput("pre-reset s_y", 32'(s_y), 6);
    reset = 1'b0;
    #1;
    checkResetState("async reset");
    repeat (3) @(posedge clk25);
    #1;
    checkResetState("held reset");
    checkOutput("held reset s_screen_end", 32'(s_screen_end), 0);

    @(negedge clk25);
    reset = 1'b1;
    #1;
    applyStimulus("run2", 922);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
